// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command interpreter.
// Operator decoding lives here so the FSM and any future stages agree on codes.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENT_A,
        WAIT_B,
        ENT_B,
        SHOW,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        MUL
    } op_e;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;

    typedef struct packed {
        logic valid;
        op_e  op;
    } op_dec_t;

    // Bytes the decoder classes as operators but this calculator does not implement come back invalid.
    function automatic op_dec_t decode_op(input logic [7:0] ch);
        op_dec_t r;
        r.valid = 1'b1;
        r.op    = ADD;
        case (ch)
            ASCII_PLUS:  r.op = ADD;
            ASCII_MINUS: r.op = SUB;
            ASCII_STAR:  r.op = MUL;
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned add/sub/mul with an overflow flag.
// A result that does not fit in W bits, or would go negative, raises ovf.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_e          op,
    output logic [W-1:0] y,
    output logic         ovf
);

    logic [W:0]     sum;
    logic [2*W-1:0] prod;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        y    = '0;
        ovf  = 1'b0;
        case (op)
            ADD: begin
                y   = sum[W-1:0];
                ovf = sum[W];
            end
            SUB: begin
                y   = a - b;
                ovf = (b > a);
            end
            MUL: begin
                y   = prod[W-1:0];
                ovf = |prod[2*W-1:W];
            end
            default: begin
                y   = '0;
                ovf = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cmd_interp_fsm.sv
// Calculator command interpreter: accumulates decimal operands, evaluates left-to-right,
// and publishes a registered result with a one-cycle valid strobe.
//
// state  | meaning
// IDLE   | nothing entered yet, display 0
// ENT_A  | entering left operand A
// WAIT_B | operator latched, waiting for first digit of B
// ENT_B  | entering right operand B
// SHOW   | result on display, may chain or start fresh
// ERR    | sticky error, only esc leaves
module cmd_interp_fsm
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   data,
    input  logic         got_dig,
    input  logic         got_op,
    input  logic         got_eq,
    input  logic         got_esc,
    output logic [W-1:0] disp,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         err,
    output logic         op_pending
);

    state_e       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    op_e          op_q, op_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] disp_q, disp_d;
    logic         result_valid_q, result_valid_d;
    logic         err_q, err_d;
    logic         op_pending_q, op_pending_d;

    logic [W-1:0] alu_y;
    logic         alu_ovf;
    op_dec_t      op_dec;
    logic [W-1:0] digit;
    logic [W-1:0] acc_src;
    logic [W+3:0] acc_src_x;
    logic [W+3:0] acc_x;
    logic         acc_ovf;

    // One ALU serves both the chaining and the eq path; both evaluate A op B.
    calc_alu #(.W(W)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        op_dec    = decode_op(data);
        digit     = {{(W-4){1'b0}}, data[3:0]};
        acc_src   = (state_q == ENT_B) ? b_q : a_q;
        acc_src_x = {4'b0000, acc_src};
        acc_x     = (acc_src_x << 3) + (acc_src_x << 1) + {{W{1'b0}}, data[3:0]};
        acc_ovf   = |acc_x[W+3:W];
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (in_valid) begin
            if (got_esc) begin
                state_d = IDLE;
                a_d     = '0;
                b_d     = '0;
                op_d    = ADD;
            end else if (state_q == ERR) begin
                state_d = ERR;
            end else if (got_eq) begin
                case (state_q)
                    ENT_A: begin
                        result_d       = a_q;
                        result_valid_d = 1'b1;
                        state_d        = SHOW;
                    end
                    WAIT_B: state_d = ERR;
                    ENT_B: begin
                        if (alu_ovf) begin
                            state_d = ERR;
                        end else begin
                            result_d       = alu_y;
                            result_valid_d = 1'b1;
                            state_d        = SHOW;
                        end
                    end
                    default: ;
                endcase
            end else if (got_op) begin
                case (state_q)
                    ENT_A, WAIT_B: begin
                        if (!op_dec.valid) begin
                            state_d = ERR;
                        end else begin
                            op_d    = op_dec.op;
                            state_d = WAIT_B;
                        end
                    end
                    ENT_B: begin
                        if (!op_dec.valid || alu_ovf) begin
                            state_d = ERR;
                        end else begin
                            a_d     = alu_y;
                            b_d     = '0;
                            op_d    = op_dec.op;
                            state_d = WAIT_B;
                        end
                    end
                    SHOW: begin
                        if (!op_dec.valid) begin
                            state_d = ERR;
                        end else begin
                            a_d     = result_q;
                            op_d    = op_dec.op;
                            state_d = WAIT_B;
                        end
                    end
                    default: ;
                endcase
            end else if (got_dig) begin
                case (state_q)
                    IDLE, SHOW: begin
                        a_d     = digit;
                        state_d = ENT_A;
                    end
                    ENT_A: begin
                        if (acc_ovf) state_d = ERR;
                        else         a_d     = acc_x[W-1:0];
                    end
                    WAIT_B: begin
                        b_d     = digit;
                        state_d = ENT_B;
                    end
                    ENT_B: begin
                        if (acc_ovf) state_d = ERR;
                        else         b_d     = acc_x[W-1:0];
                    end
                    default: ;
                endcase
            end
        end

        err_d        = (state_d == ERR);
        op_pending_d = (state_d == WAIT_B);
        case (state_d)
            ENT_A, WAIT_B: disp_d = a_d;
            ENT_B:         disp_d = b_d;
            SHOW:          disp_d = result_d;
            default:       disp_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= ADD;
            result_q       <= '0;
            disp_q         <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            op_pending_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            disp_q         <= disp_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            op_pending_q   <= op_pending_d;
        end
    end

    assign disp         = disp_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign op_pending   = op_pending_q;

endmodule

// File: doc/cmd_interp_fsm.md
# cmd_interp_fsm

Calculator command interpreter directly downstream of `cmd_interp_decoder`. It takes the received ASCII byte and the decoder's class flags (`got_dig`, `got_op`, `got_eq`, `got_esc`) and accumulates decimal operands. It applies `+`, `-` and `*` left-to-right and publishes a registered result with a one-cycle valid strobe. All error conditions latch until ESC.

## Interface

- `W`, 16: operand/result width, unsigned.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  one-cycle strobe; `data` and the flags are sampled only when it is high.
- `data`  in  8  ASCII byte from the decoder stage.
- `got_dig`, `got_op`, `got_eq`, `got_esc`  in  1 each  decoder class flags.
- `disp`  out  W  value currently being entered, or the last result.
- `result`  out  W  last computed result.
- `result_valid`  out  1  one-cycle pulse when `result` updates on `=`.
- `err`  out  1  sticky error; cleared only by ESC or `rst`.
- `op_pending`  out  1  high while an operator is latched and waiting for its right operand.

## Operation

- Accepted event: `in_valid`=1. If several flags are set, priority is esc > eq > op > dig. No flag set means the event is ignored.
- Digit value: `data[3:0]`.
- Operator codes:
  - 0x2B selects add.
  - 0x2D selects sub.
  - 0x2A selects mul.
  - Any other `got_op` byte (0x2C, 0x2E, 0x2F) sends the FSM to ERR.
- Accumulate: `acc = acc*10 + d`. If this exceeds 2^W-1, go to ERR.
- Arithmetic rules:
  - add overflow sets error.
  - sub with b > a sets error (no negatives).
  - mul: a 2W-bit product with a nonzero upper half sets error.
- States and transitions:
  - IDLE:
    - dig: A=d, go to ENT_A.
    - op/eq: ignored.
  - ENT_A:
    - dig: accumulate A.
    - op: latch op, go to WAIT_B.
    - eq: result=A, pulse `result_valid`, go to SHOW.
  - WAIT_B:
    - dig: B=d, go to ENT_B.
    - op: replace the latched op.
    - eq: go to ERR.
  - ENT_B:
    - dig: accumulate B.
    - op: A=A op B, latch the new op, go to WAIT_B (chaining).
    - eq: result=A op B, pulse `result_valid`, go to SHOW.
    - An arithmetic error on either path goes to ERR.
  - SHOW:
    - dig: A=d, go to ENT_A (fresh entry).
    - op: A=result, latch op, go to WAIT_B.
    - eq: ignored.
  - ERR: everything except esc is ignored.
  - esc, from any state: clear A, B, op and `err`; go to IDLE. `result` is kept.
- `disp` shows A in ENT_A and WAIT_B, B in ENT_B, `result` in SHOW, and 0 in IDLE and ERR.

## Timing

- Reset values: state IDLE; A, B, `result` and `disp` are 0; `result_valid`, `err` and `op_pending` are 0.
- Latency: all outputs register on the same edge that samples the event, so they are visible the cycle after the `in_valid` cycle.
- `result_valid` is high for exactly one cycle per accepted eq that computes. It is never asserted by an eq that leads to ERR, and never asserted in ERR.
- `err` rises on the edge that enters ERR and holds until an accepted esc or `rst`.
- `rst` asserted mid-entry or mid-chain overrides any simultaneous `in_valid` event.
- Back-to-back `in_valid` on every cycle is supported. No backpressure.

## Structure

- `calc_pkg` holds:
  - the state enum: IDLE, ENT_A, WAIT_B, ENT_B, SHOW, ERR;
  - the op enum: ADD, SUB, MUL;
  - the ASCII constants 0x2B, 0x2D, 0x2A, 0x3D, 0x1B.
- `calc_alu` is a sub-module: a combinational W-bit add/sub/mul with an `ovf` output. The FSM instantiates it once and shares it between the chaining and eq paths.
- The digit-accumulate ×10 is done inline as `(acc<<3)+(acc<<1)` at W+4 bits, with an overflow compare.

## Test plan

- "12+34=" → `result`=46, one `result_valid` pulse, `err`=0.
- "7*6=" then "+8=" → first `result`=42, then `result`=50 (SHOW chaining).
- "2+3*4=" → `result`=20 (left-to-right); `op_pending`=1 after each operator.
- "5-7=" → `err`=1, no `result_valid`. Then digits are ignored and ESC clears `err` with state returning to IDLE.
- With W=16:
  - "65535+1=" → ERR.
  - "70000" → ERR on the fifth digit.
  - "0x2E" as op → ERR.
- `rst` asserted after "12+3" → next cycle state IDLE, `disp`=0, `op_pending`=0. Then "9=" → `result`=9.
